mem_bus_arbiter: RTL and testbench

Parametrised N-channel arbiter between cache-side memory-bus masters and the single memory port. It generalises the fixed two-channel instruction/data bus controller. Additions:
- any channel count,
- round-robin or fixed-priority mode,
- pipelined reads, with up to OUTSTANDING read requests in flight at once.

Read responses are routed back to the issuing channel through an in-order ID FIFO.

---
 rtl/mem_bus_arbiter_pkg.sv | 14 +
 rtl/mem_bus_arbiter_id_fifo.sv | 60 ++++++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared helpers for the memory-bus arbiter: channel-ID sizing and packed-bus slicing.
package mem_bus_arbiter_pkg;

  // Width of a channel index; at least one bit even for a single channel.
  function automatic int unsigned id_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Low bit of channel idx inside a packed per-channel bus of element width w.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_id_fifo.sv
// In-order FIFO of channel IDs for reads in flight; any depth, pointers wrap mod DEPTH.
module mem_bus_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags, guarded push/pop and head-of-queue view.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = slots[rd_ptr];
  end

  // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-channel arbiter onto one memory port with pipelined, in-order read response routing.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned OUTSTANDING = 1,
  parameter int unsigned RR_MODE     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_req_valid,
  output logic [NUM_CH-1:0]            ch_req_ready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_req_addr,
  input  logic [NUM_CH-1:0]            ch_req_wen,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_req_wdata,
  output logic [NUM_CH-1:0]            ch_resp_valid,
  output logic [DATA_WIDTH-1:0]        ch_resp_rdata,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  output logic                         mem_req_wen,
  output logic [DATA_WIDTH-1:0]        mem_req_wdata,
  input  logic                         mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]        mem_resp_rdata,
  output logic                         err_resp
);

  localparam int unsigned ID_W  = id_width(NUM_CH);
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  typedef logic [ID_W-1:0] ch_id_t;

  ch_id_t                ptr;
  ch_id_t                grant;
  ch_id_t                cand;
  ch_id_t                fifo_head;
  logic                  found;
  logic                  any_valid;
  logic                  grant_wen;
  logic                  blocked;
  logic                  transfer;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CH];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_arr[i]  = ch_req_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wdata_arr[i] = ch_req_wdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
  end

  // Priority search: first valid channel starting at ptr (round-robin) or at 0 (fixed).
  always_comb begin
    any_valid = |ch_req_valid;
    grant     = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) begin
        cand = ch_id_t'((32'(ptr) + k) % NUM_CH);
      end else begin
        cand = ch_id_t'(k);
      end
      if (!found && ch_req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Request mux, read blocking on a full ID FIFO, and response routing.
  always_comb begin
    grant_wen     = ch_req_wen[grant];
    blocked       = any_valid & ~grant_wen & fifo_full;
    mem_req_valid = any_valid & ~blocked;
    mem_req_addr  = any_valid ? addr_arr[grant]  : '0;
    mem_req_wdata = any_valid ? wdata_arr[grant] : '0;
    mem_req_wen   = any_valid & grant_wen;
    transfer      = mem_req_valid & mem_req_ready;
    push          = transfer & ~grant_wen;
    pop           = mem_resp_valid & ~fifo_empty;
    ch_req_ready  = '0;
    if (transfer) begin
      ch_req_ready[grant] = 1'b1;
    end
    ch_resp_valid = '0;
    if (pop) begin
      ch_resp_valid[fifo_head] = 1'b1;
    end
    ch_resp_rdata = mem_resp_rdata;
  end

  // Round-robin pointer advances past the channel that just transferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (transfer && RR_MODE != 0) begin
      ptr <= (grant == ch_id_t'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Sticky flag for a memory response that no read was waiting for.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_resp <= 1'b0;
    end else if (mem_resp_valid && fifo_empty) begin
      err_resp <= 1'b1;
    end
  end

  // Occupancy can never exceed the configured read depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (fifo_count <= CNT_W'(OUTSTANDING));
    end
  end

  mem_bus_arbiter_id_fifo #(
    .DEPTH(OUTSTANDING),
    .WIDTH(ID_W)
  ) u_id_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(grant),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed multi-cycle sequences, randomized model check.
module tb_mem_bus_arbiter;

  localparam int NCH  = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int OUTS = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_req_valid;
  logic [NCH-1:0]    ch_req_wen;
  logic [NCH*AW-1:0] ch_req_addr;
  logic [NCH*DW-1:0] ch_req_wdata;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_rdata;

  logic [NCH-1:0]    ch_req_ready, ch_resp_valid;
  logic [DW-1:0]     ch_resp_rdata;
  logic              mem_req_valid, mem_req_wen, err_resp;
  logic [AW-1:0]     mem_req_addr;
  logic [DW-1:0]     mem_req_wdata;

  logic [NCH-1:0]    fp_ch_req_ready, fp_ch_resp_valid;
  logic [DW-1:0]     fp_ch_resp_rdata;
  logic              fp_mem_req_valid, fp_mem_req_wen, fp_err_resp;
  logic [AW-1:0]     fp_mem_req_addr;
  logic [DW-1:0]     fp_mem_req_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OUTS), .RR_MODE(1)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_req_addr(ch_req_addr), .ch_req_wen(ch_req_wen), .ch_req_wdata(ch_req_wdata),
    .ch_resp_valid(ch_resp_valid), .ch_resp_rdata(ch_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .err_resp(err_resp)
  );

  mem_bus_arbiter #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OUTS), .RR_MODE(0)
  ) dut_fp (
    .clk(clk), .reset(reset),
    .ch_req_valid(ch_req_valid), .ch_req_ready(fp_ch_req_ready),
    .ch_req_addr(ch_req_addr), .ch_req_wen(ch_req_wen), .ch_req_wdata(ch_req_wdata),
    .ch_resp_valid(fp_ch_resp_valid), .ch_resp_rdata(fp_ch_resp_rdata),
    .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(fp_mem_req_addr), .mem_req_wen(fp_mem_req_wen), .mem_req_wdata(fp_mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .err_resp(fp_err_resp)
  );

  typedef struct {
    logic [NCH-1:0] valid;
    logic           rdy;
    int             g_rr;
    logic [NCH-1:0] exp_rr;
    logic [NCH-1:0] exp_fp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ch_req_valid   = '0;
    ch_req_wen     = '0;
    ch_req_addr    = '0;
    ch_req_wdata   = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic set_rd(input int ch, input logic [AW-1:0] a);
    ch_req_valid[ch]          = 1'b1;
    ch_req_wen[ch]            = 1'b0;
    ch_req_addr[ch*AW +: AW]  = a;
  endtask

  task automatic set_wr(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_req_valid[ch]          = 1'b1;
    ch_req_wen[ch]            = 1'b1;
    ch_req_addr[ch*AW +: AW]  = a;
    ch_req_wdata[ch*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, ch_req_ready, 0);
    chk({tag, "_resp_valid"}, ch_resp_valid, 0);
    chk({tag, "_resp_rdata"}, ch_resp_rdata, 0);
    chk({tag, "_mem_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_addr"}, mem_req_addr, 0);
    chk({tag, "_mem_wen"}, mem_req_wen, 0);
    chk({tag, "_mem_wdata"}, mem_req_wdata, 0);
    chk({tag, "_err"}, err_resp, 0);
  endtask

  // Random-phase reference state
  int              m_ptr;
  int              m_q[$];
  bit              m_err;
  bit              pend  [NCH];
  logic [AW-1:0]   paddr [NCH];
  bit              pwen  [NCH];
  logic [DW-1:0]   pwd   [NCH];

  initial begin
    tbl[0]  = '{4'b1111, 1'b1,  0, 4'b0001, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1,  1, 4'b0010, 4'b0001};
    tbl[2]  = '{4'b1111, 1'b1,  2, 4'b0100, 4'b0001};
    tbl[3]  = '{4'b1111, 1'b1,  3, 4'b1000, 4'b0001};
    tbl[4]  = '{4'b1111, 1'b1,  0, 4'b0001, 4'b0001};
    tbl[5]  = '{4'b1010, 1'b1,  1, 4'b0010, 4'b0010};
    tbl[6]  = '{4'b1010, 1'b1,  3, 4'b1000, 4'b0010};
    tbl[7]  = '{4'b1010, 1'b0,  1, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1000, 1'b1,  3, 4'b1000, 4'b1000};
    tbl[9]  = '{4'b0000, 1'b1, -1, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0001, 1'b1,  0, 4'b0001, 4'b0001};
    tbl[11] = '{4'b0100, 1'b1,  2, 4'b0100, 4'b0100};

    // Reset state
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_all_zero("rst");
    chk("rst_fp_mem_valid", fp_mem_req_valid, 0);
    chk("rst_fp_err", fp_err_resp, 0);

    // Writes-only vector table: round-robin order and fixed priority side by side
    do_reset();
    for (int r = 0; r < 12; r++) begin
      idle();
      for (int i = 0; i < NCH; i++) begin
        ch_req_addr[i*AW +: AW]  = 32'h1000 + 32'(i) * 32'h10;
        ch_req_wdata[i*DW +: DW] = 32'hD0 + 32'(i);
      end
      ch_req_valid  = tbl[r].valid;
      ch_req_wen    = '1;
      mem_req_ready = tbl[r].rdy;
      #1;
      chk($sformatf("tbl%0d_rr_ready", r), ch_req_ready, tbl[r].exp_rr);
      chk($sformatf("tbl%0d_fp_ready", r), fp_ch_req_ready, tbl[r].exp_fp);
      chk($sformatf("tbl%0d_rr_addr", r), mem_req_addr,
          (tbl[r].g_rr >= 0) ? 32'h1000 + 32'(tbl[r].g_rr) * 32'h10 : 32'h0);
      chk($sformatf("tbl%0d_rr_wen", r), mem_req_wen, (tbl[r].g_rr >= 0) ? 1 : 0);
      @(negedge clk);
    end

    // Pipelined reads and routing, memory latency 4
    do_reset();
    set_rd(2, 'h100);
    #1;
    chk("pipe0_ready", ch_req_ready, 4'b0100);
    chk("pipe0_addr", mem_req_addr, 'h100);
    chk("pipe0_wen", mem_req_wen, 0);
    @(negedge clk); idle(); set_rd(0, 'h200);
    #1;
    chk("pipe1_ready", ch_req_ready, 4'b0001);
    chk("pipe1_addr", mem_req_addr, 'h200);
    @(negedge clk); idle(); set_rd(1, 'h300);
    #1;
    chk("pipe2_mem_valid", mem_req_valid, 0);
    chk("pipe2_ready", ch_req_ready, 0);
    @(negedge clk);
    #1;
    chk("pipe3_mem_valid", mem_req_valid, 0);
    @(negedge clk); mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE0100;
    #1;
    chk("pipe4_resp", ch_resp_valid, 4'b0100);
    chk("pipe4_rdata", ch_resp_rdata, 32'hCAFE0100);
    chk("pipe4_full_blocks", mem_req_valid, 0);
    chk("pipe4_ready", ch_req_ready, 0);
    @(negedge clk); mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE0200;
    #1;
    chk("pipe5_resp", ch_resp_valid, 4'b0001);
    chk("pipe5_ready", ch_req_ready, 4'b0010);
    chk("pipe5_addr", mem_req_addr, 'h300);
    @(negedge clk); idle();
    #1;
    chk("pipe6_resp", ch_resp_valid, 0);
    repeat (3) @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE0300;
    #1;
    chk("pipe9_resp", ch_resp_valid, 4'b0010);
    chk("pipe9_err", err_resp, 0);

    // Full FIFO: pending write goes through, pending read stays blocked even on a pop
    do_reset();
    set_rd(0, 'h10);
    #1;
    chk("full0_ready", ch_req_ready, 4'b0001);
    @(negedge clk); idle(); set_rd(1, 'h20);
    #1;
    chk("full1_ready", ch_req_ready, 4'b0010);
    @(negedge clk); idle(); set_rd(0, 'h30); set_wr(3, 'h40, 'h5A5A);
    #1;
    chk("full2_mem_valid", mem_req_valid, 1);
    chk("full2_ready", ch_req_ready, 4'b1000);
    chk("full2_wen", mem_req_wen, 1);
    chk("full2_wdata", mem_req_wdata, 'h5A5A);
    @(negedge clk); idle(); set_rd(0, 'h30); mem_resp_valid = 1'b1; mem_resp_rdata = 1;
    #1;
    chk("full3_mem_valid", mem_req_valid, 0);
    chk("full3_ready", ch_req_ready, 0);
    chk("full3_resp", ch_resp_valid, 4'b0001);
    @(negedge clk); idle(); set_rd(0, 'h30);
    #1;
    chk("full4_ready", ch_req_ready, 4'b0001);
    chk("full4_addr", mem_req_addr, 'h30);
    @(negedge clk); idle(); mem_resp_valid = 1'b1;
    #1;
    chk("full5_resp", ch_resp_valid, 4'b0010);
    @(negedge clk); idle(); mem_resp_valid = 1'b1;
    #1;
    chk("full6_resp", ch_resp_valid, 4'b0001);
    @(negedge clk); idle();
    #1;
    chk("full7_err", err_resp, 0);

    // Unexpected response after reset
    do_reset();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234;
    #1;
    chk("unexp0_resp", ch_resp_valid, 0);
    chk("unexp0_err", err_resp, 0);
    @(negedge clk); idle();
    #1;
    chk("unexp1_err", err_resp, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("unexp4_err", err_resp, 1);

    // Reset mid-operation: err set, two reads outstanding, ptr=3
    do_reset();
    set_rd(1, 'h11); mem_resp_valid = 1'b1;
    #1;
    chk("midrst0_ready", ch_req_ready, 4'b0010);
    chk("midrst0_resp", ch_resp_valid, 0);
    @(negedge clk); idle(); set_rd(2, 'h22);
    #1;
    chk("midrst1_ready", ch_req_ready, 4'b0100);
    @(negedge clk); idle(); reset = 1'b1;
    #1;
    chk("midrst2_err_before", err_resp, 1);
    @(negedge clk); reset = 1'b0;
    #1;
    chk_all_zero("midrst3");
    @(negedge clk); idle(); ch_req_valid = '1; ch_req_wen = '1;
    #1;
    chk("midrst4_ptr0", ch_req_ready, 4'b0001);
    @(negedge clk); idle(); mem_resp_valid = 1'b1;
    #1;
    chk("midrst5_resp", ch_resp_valid, 0);
    @(negedge clk); idle();
    #1;
    chk("midrst6_err", err_resp, 1);

    // Randomized traffic against a reference model (round-robin instance)
    do_reset();
    m_ptr = 0;
    m_q.delete();
    m_err = 1'b0;
    for (int i = 0; i < NCH; i++) pend[i] = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      int g;
      int best;
      bit exp_mv, xfer, full;
      logic [NCH-1:0] exp_rdy, exp_resp;
      idle();
      for (int i = 0; i < NCH; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1'b1;
          paddr[i] = $urandom;
          pwen[i]  = ($urandom_range(0, 1) == 1);
          pwd[i]   = $urandom;
        end
        ch_req_valid[i]          = pend[i];
        ch_req_wen[i]            = pwen[i];
        ch_req_addr[i*AW +: AW]  = paddr[i];
        ch_req_wdata[i*DW +: DW] = pwd[i];
      end
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_resp_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_resp_rdata = $urandom;
      #1;
      // Winner is the pending channel at the smallest rotational distance from the pointer
      g = -1;
      best = NCH;
      for (int i = 0; i < NCH; i++) begin
        if (pend[i] && ((i - m_ptr + NCH) % NCH) < best) begin
          best = (i - m_ptr + NCH) % NCH;
          g = i;
        end
      end
      full     = (m_q.size() == OUTS);
      exp_mv   = (g >= 0) && (pwen[g] || !full);
      xfer     = exp_mv && mem_req_ready;
      exp_rdy  = xfer ? (NCH'(1) << g) : '0;
      exp_resp = (mem_resp_valid && m_q.size() > 0) ? (NCH'(1) << m_q[0]) : '0;
      chk("rand_ready", ch_req_ready, exp_rdy);
      chk("rand_mem_valid", mem_req_valid, exp_mv);
      chk("rand_addr", mem_req_addr, (g >= 0) ? paddr[g] : '0);
      chk("rand_wen", mem_req_wen, (g >= 0) ? pwen[g] : 1'b0);
      chk("rand_wdata", mem_req_wdata, (g >= 0) ? pwd[g] : '0);
      chk("rand_resp", ch_resp_valid, exp_resp);
      chk("rand_rdata", ch_resp_rdata, mem_resp_rdata);
      chk("rand_err", err_resp, m_err);
      if (mem_resp_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (xfer) begin
        if (!pwen[g]) m_q.push_back(g);
        pend[g] = 1'b0;
        m_ptr = (g + 1) % NCH;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
